// File: rtl/phase_sequencer.sv
// Instruction-cycle phase generator: one-hot FETCH/DECODE/EXECUTE/COMMIT strobes with
// wait-state stretching, an optional second E/C pass, run/step control and a sticky halt.
module phase_sequencer #(
  parameter int COUNT_WIDTH = 16,
  parameter int WAIT_MAX    = 15
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   RUN,
  input  logic                   STEP,
  input  logic                   HALT_REQ,
  input  logic                   WAIT,
  input  logic                   EXTEND,
  output logic                   FETCH,
  output logic                   DECODE,
  output logic                   EXECUTE,
  output logic                   COMMIT,
  output logic [1:0]             PHASEX,
  output logic                   HALTED,
  output logic                   TIMEOUT,
  output logic [COUNT_WIDTH-1:0] INSTR_COUNT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F    = 3'd1;
  localparam logic [2:0] S_D    = 3'd2;
  localparam logic [2:0] S_E    = 3'd3;
  localparam logic [2:0] S_C    = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       halt_pend;
  logic       ext_flag;
  logic       pass2;
  logic [7:0] wait_cnt;
  logic       in_instr;
  logic       retire;
  logic       wait_hit;

  always_comb begin
    in_instr  = (state == S_F) || (state == S_D) || (state == S_E) || (state == S_C);
    wait_hit  = (state == S_E) && WAIT && (wait_cnt == WAIT_LIM);
    // A commit only retires when no second pass is still owed.
    retire    = (state == S_C) && !(ext_flag && !pass2);
    state_nxt = state;
    case (state)
      S_IDLE: if (RUN || STEP) state_nxt = S_F;
      S_F:    state_nxt = S_D;
      S_D:    state_nxt = S_E;
      S_E:    if (!WAIT || wait_hit) state_nxt = S_C;
      S_C: begin
        if (!retire)                    state_nxt = S_E;
        else if (halt_pend || HALT_REQ) state_nxt = S_HALT;
        else if (RUN)                   state_nxt = S_F;
        else                            state_nxt = S_IDLE;
      end
      S_HALT: if (!HALT_REQ && (RUN || STEP)) state_nxt = S_F;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      FETCH       <= 1'b0;
      DECODE      <= 1'b0;
      EXECUTE     <= 1'b0;
      COMMIT      <= 1'b0;
      PHASEX      <= 2'b00;
      HALTED      <= 1'b0;
      TIMEOUT     <= 1'b0;
      INSTR_COUNT <= '0;
      halt_pend   <= 1'b0;
      ext_flag    <= 1'b0;
      pass2       <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      state   <= state_nxt;
      FETCH   <= (state_nxt == S_F);
      DECODE  <= (state_nxt == S_D);
      EXECUTE <= (state_nxt == S_E);
      COMMIT  <= (state_nxt == S_C);
      HALTED  <= (state_nxt == S_HALT);
      case (state_nxt)
        S_D:     PHASEX <= 2'b01;
        S_E:     PHASEX <= 2'b10;
        S_C:     PHASEX <= 2'b11;
        default: PHASEX <= 2'b00;
      endcase
      TIMEOUT <= wait_hit;

      if (retire) INSTR_COUNT <= INSTR_COUNT + COUNT_WIDTH'(1);

      // Retire clears the latch even if HALT_REQ is still high; that request is consumed here.
      if (retire)                    halt_pend <= 1'b0;
      else if (in_instr && HALT_REQ) halt_pend <= 1'b1;

      if (state == S_D) begin
        ext_flag <= EXTEND;
        pass2    <= 1'b0;
      end else if (state == S_C) begin
        if (retire) ext_flag <= 1'b0;
        else        pass2    <= 1'b1;
      end

      if (state == S_E) begin
        if (WAIT && (wait_cnt < WAIT_LIM)) wait_cnt <= wait_cnt + 8'd1;
        else                               wait_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed steps then random stimulus, each cycle compared
// against an instruction-level behavioural model.
module tb_phase_sequencer;
  localparam int CW = 4;
  localparam int WM = 15;
  localparam int P_IDLE = 0, P_F = 1, P_D = 2, P_E = 3, P_C = 4, P_HALT = 5;

  logic clk = 1'b0;
  logic rst_n, run, step, halt_req, wt, ext;
  logic fetch, decode, execute, commit, halted, timeout;
  logic [1:0] phasex;
  logic [CW-1:0] icount;

  int total = 0;
  int bad = 0;
  int m_ph, m_cnt, m_wt;
  bit m_hp, m_ext, m_p2, m_to;
  int e_streak = 0;
  int last_e = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.COUNT_WIDTH(CW), .WAIT_MAX(WM)) dut (
    .CLK(clk), .RESET_N(rst_n), .RUN(run), .STEP(step), .HALT_REQ(halt_req),
    .WAIT(wt), .EXTEND(ext), .FETCH(fetch), .DECODE(decode), .EXECUTE(execute),
    .COMMIT(commit), .PHASEX(phasex), .HALTED(halted), .TIMEOUT(timeout),
    .INSTR_COUNT(icount)
  );

  // Behavioural model: where the instruction is, and what it still owes.
  task automatic model_step(input bit r, input bit ru, input bit st, input bit hr,
                            input bit w, input bit ex);
    if (!r) begin
      m_ph = P_IDLE; m_cnt = 0; m_wt = 0;
      m_hp = 0; m_ext = 0; m_p2 = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (hr && m_ph >= P_F && m_ph <= P_C) m_hp = 1;
    if (m_ph == P_IDLE) begin
      if (ru || st) m_ph = P_F;
    end else if (m_ph == P_F) begin
      m_ph = P_D;
    end else if (m_ph == P_D) begin
      m_ext = ex; m_p2 = 0; m_ph = P_E;
    end else if (m_ph == P_E) begin
      if (w && m_wt < WM) m_wt = m_wt + 1;
      else begin
        m_to = w;
        m_wt = 0;
        m_ph = P_C;
      end
    end else if (m_ph == P_C) begin
      if (m_ext && !m_p2) begin
        m_p2 = 1; m_ph = P_E;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ext = 0;
        if (m_hp) begin m_hp = 0; m_ph = P_HALT; end
        else m_ph = ru ? P_F : P_IDLE;
      end
    end else begin
      if (!hr && (ru || st)) m_ph = P_F;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic [1:0] px;
    px = (m_ph == P_D) ? 2'b01 : (m_ph == P_E) ? 2'b10 : (m_ph == P_C) ? 2'b11 : 2'b00;
    return {m_ph == P_F, m_ph == P_D, m_ph == P_E, m_ph == P_C, px, m_ph == P_HALT,
            m_to, CW'(m_cnt)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit ru, input bit st, input bit hr,
                       input bit w, input bit ex);
    logic [11:0] obs;
    rst_n = r; run = ru; step = st; halt_req = hr; wt = w; ext = ex;
    model_step(r, ru, st, hr, w, ex);
    @(posedge clk);
    @(negedge clk);
    obs = {fetch, decode, execute, commit, phasex, halted, timeout, icount};
    total++;
    assert (obs === exp_vec()) else begin
      bad++;
      $error("FAIL cycle_model observed=%h expected=%h", obs, exp_vec());
    end
    if (execute === 1'b1) e_streak++;
    else begin
      if (e_streak != 0) last_e = e_streak;
      e_streak = 0;
    end
  endtask

  initial begin
    bit r, ru, w, hr, st, ex;
    int wprob;
    // reset state
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 1);
    chk("rst_strobes", {fetch, decode, execute, commit}, 0);
    chk("rst_phasex", phasex, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", icount, 0);

    // free run, no wait
    cycle(1, 1, 0, 0, 0, 0); chk("run_f", {fetch, phasex}, 3'b100);
    cycle(1, 1, 0, 0, 0, 0); chk("run_d", {decode, phasex}, 3'b101);
    cycle(1, 1, 0, 0, 0, 0); chk("run_e", {execute, phasex}, 3'b110);
    cycle(1, 1, 0, 0, 0, 0); chk("run_c", {commit, phasex}, 3'b111);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("run_c3", commit, 1);
    chk("run_cnt2", icount, 2);
    cycle(1, 0, 0, 0, 0, 0);
    chk("run_cnt3", icount, 3);
    chk("run_idle", {fetch, decode, execute, commit}, 0);

    // three wait states
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("wait_commit", commit, 1);
    chk("wait_elen", last_e, 4);
    chk("wait_noto", timeout, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("wait_cnt", icount, 4);

    // wait held until timeout
    cycle(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 40 && commit !== 1'b1; i++) cycle(1, 1, 0, 0, 1, 0);
    chk("to_commit", commit, 1);
    chk("to_elen", last_e, WM + 1);
    chk("to_pulse", timeout, 1);
    cycle(1, 0, 0, 0, 1, 0);
    chk("to_pulse_end", timeout, 0);
    chk("to_cnt", icount, 5);

    // extended instruction with halt request in first execute
    cycle(1, 0, 1, 0, 0, 0); chk("ext_f", fetch, 1);
    cycle(1, 0, 0, 0, 0, 0); chk("ext_d", decode, 1);
    cycle(1, 0, 0, 0, 0, 1); chk("ext_e1", execute, 1);
    cycle(1, 0, 0, 1, 0, 0); chk("ext_c1", commit, 1);
    cycle(1, 0, 0, 0, 0, 0); chk("ext_e2", execute, 1);
    chk("ext_noretire", icount, 5);
    cycle(1, 0, 0, 0, 0, 0); chk("ext_c2", commit, 1);
    cycle(1, 1, 0, 0, 0, 0); chk("ext_halted", halted, 1);
    chk("ext_cnt", icount, 6);
    chk("ext_halt_strobes", {fetch, decode, execute, commit}, 0);

    // single step from HALT, then from IDLE
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 1, 0, 0, 0); chk("step_f", fetch, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
      chk("step_c", commit, 1);
      cycle(1, 0, 0, 0, 0, 0);
      chk("step_idle", {fetch, decode, execute, commit, halted}, 0);
      chk("step_cnt", icount, 7 + k);
    end

    // reset in the middle of an extended instruction
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0); chk("mid_e2", execute, 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("mid_rst_strobes", {fetch, decode, execute, commit}, 0);
    chk("mid_rst_cnt", icount, 0);
    cycle(1, 1, 0, 0, 0, 0); chk("mid_first_fetch", fetch, 1);

    // counter wrap at 2^CW retires
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("wrap_allones", icount, (1 << CW) - 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("wrap_zero", icount, 0);

    // random traffic
    wprob = 0; ru = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: wprob = 0;
          1: wprob = 30;
          2: wprob = 90;
          default: wprob = 100;
        endcase
        ru = ($urandom_range(0, 2) != 0);
      end
      r  = ($urandom_range(0, 499) != 0);
      st = ($urandom_range(0, 9) == 0);
      hr = ($urandom_range(0, 39) == 0);
      ex = ($urandom_range(0, 2) == 0);
      w  = ($urandom_range(1, 100) <= wprob);
      cycle(r, ru, st, hr, w, ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
